maindec_multicycle: RTL

Multicycle LEGv8 control unit and the successor to the single-cycle main decoder. It sequences each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to instruction and data memory, and holds per-instruction control fields across states. It adds a bounded memory-wait timeout, a sticky fault state and a retired-instruction counter. It sits between the instruction register and the multicycle datapath.

---
 rtl/maindec_pkg.sv | 43 ++++
 rtl/maindec_multicycle_if.sv | 13 +
 rtl/maindec_classify.sv | 18 +
 rtl/maindec_multicycle.sv | 106 ++++++++++
 4 files changed

// File: rtl/maindec_pkg.sv
// maindec_pkg: shared types, opcode constants and static control fields for the multicycle LEGv8 decoder
package maindec_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_t;
  typedef enum logic [2:0] {
    R    = 3'd0,
    LDUR = 3'd1,
    STUR = 3'd2,
    CBZ  = 3'd3,
    ILL  = 3'd4
  } iclass_t;
  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic [1:0] aluop;
  } ctrl_t;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] CBZ_MASK = 11'b11111111000;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam ctrl_t CTRL_R    = '{reg2loc: 1'b0, alusrc: 1'b0, memtoreg: 1'b0, aluop: 2'b10};
  localparam ctrl_t CTRL_LDUR = '{reg2loc: 1'b0, alusrc: 1'b1, memtoreg: 1'b1, aluop: 2'b00};
  localparam ctrl_t CTRL_STUR = '{reg2loc: 1'b1, alusrc: 1'b1, memtoreg: 1'b0, aluop: 2'b00};
  localparam ctrl_t CTRL_CBZ  = '{reg2loc: 1'b1, alusrc: 1'b0, memtoreg: 1'b0, aluop: 2'b01};
  function automatic ctrl_t ctrl_of(iclass_t c);
    return c == R    ? CTRL_R    :
           c == LDUR ? CTRL_LDUR :
           c == STUR ? CTRL_STUR :
           c == CBZ  ? CTRL_CBZ  : ctrl_t'('0);
  endfunction
endpackage

// File: rtl/maindec_multicycle_if.sv
// maindec_multicycle_if: instruction/data memory handshake bundle
//   imem_req/imem_ack + Op : instruction fetch, Op valid while imem_ack=1
//   dmem_req/dmem_ack      : data access
//   master = control unit side, slave = memory side
interface maindec_multicycle_if;
  logic        imem_req;
  logic        imem_ack;
  logic [10:0] Op;
  logic        dmem_req;
  logic        dmem_ack;
  modport master(output imem_req, dmem_req, input imem_ack, dmem_ack, Op);
  modport slave(input imem_req, dmem_req, output imem_ack, dmem_ack, Op);
endinterface

// File: rtl/maindec_classify.sv
// maindec_classify: combinational opcode to instruction class and static control fields
//   op   : latched 11-bit opcode
//   cls  : instruction class (ILL for anything unrecognised)
//   ctrl : Reg2Loc/ALUSrc/MemtoReg/ALUOp for that class, all zero for ILL
module maindec_classify
  import maindec_pkg::*;
(
  input  logic [10:0] op,
  output iclass_t     cls,
  output ctrl_t       ctrl
);
  assign cls = op == OP_LDUR                 ? LDUR :
               op == OP_STUR                 ? STUR :
               (op & CBZ_MASK) == OP_CBZ     ? CBZ  :
               (op == OP_ADD || op == OP_SUB ||
                op == OP_AND || op == OP_ORR) ? R    : ILL;
  assign ctrl = ctrl_of(cls);
endmodule

// File: rtl/maindec_multicycle.sv
// maindec_multicycle: multicycle LEGv8 control FSM with memory-wait timeout, sticky fault and retire counter
//   clk, reset (async, active-low), run
//   mem      : memory handshake interface (master)
//   IRWrite/PCWrite pulse on fetch ack; Reg2Loc/ALUSrc/MemtoReg/ALUOp held DECODE..retire
//   RegWrite/MemRead/MemWrite/Branch strobes; state, fault, retired
//   ILLEGAL_TRAP_EN: when defined, an illegal opcode traps to FAULT instead of retiring as a NOP
module maindec_multicycle
  import maindec_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = $clog2(TIMEOUT + 1),
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  maindec_multicycle_if.master mem,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);
  state_t          state_q, state_n;
  logic [10:0]     op_q;
  logic [TO_W-1:0] to_q, to_n;
  iclass_t         cls;
  ctrl_t           ctrl, fld;
  logic            retire, waiting, timed_out, fetch_ack;
  maindec_classify u_classify (.op(op_q), .cls(cls), .ctrl(ctrl));
  assign fetch_ack    = state_q == FETCH && mem.imem_ack;
  // count reaching TIMEOUT on this cycle means the wait has lasted TIMEOUT cycles
  assign timed_out    = to_q == TO_W'(TIMEOUT - 1);
  assign mem.imem_req = state_q == FETCH;
  assign mem.dmem_req = state_q == MEM;
  assign IRWrite      = fetch_ack;
  assign PCWrite      = fetch_ack;
  assign RegWrite     = state_q == WB;
  assign MemRead      = state_q == MEM && cls == LDUR;
  assign MemWrite     = state_q == MEM && cls == STUR;
  assign Branch       = state_q == EXEC && cls == CBZ;
  assign fault        = state_q == FAULT;
  assign state        = state_q;
  // static fields come from the latched opcode, gated to the instruction's active states
  assign fld          = (state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB) ? ctrl : '0;
  assign Reg2Loc      = fld.reg2loc;
  assign ALUSrc       = fld.alusrc;
  assign MemtoReg     = fld.memtoreg;
  assign ALUOp        = fld.aluop;
  always_comb begin
    state_n = state_q;
    retire  = 1'b0;
    waiting = 1'b0;
    case (state_q)
      IDLE:   state_n = run ? FETCH : IDLE;
      FETCH: begin
        waiting = !mem.imem_ack;
        state_n = mem.imem_ack ? DECODE : timed_out ? FAULT : FETCH;
      end
      DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        state_n = cls == ILL ? FAULT : EXEC;
`else
        retire  = cls == ILL;
        state_n = EXEC;
`endif
      end
      EXEC: begin
        retire  = cls == CBZ;
        state_n = cls == R ? WB : MEM;
      end
      MEM: begin
        waiting = !mem.dmem_ack;
        retire  = mem.dmem_ack && cls == STUR;
        state_n = mem.dmem_ack ? WB : timed_out ? FAULT : MEM;
      end
      WB:     retire = 1'b1;
      FAULT:  state_n = FAULT;
      default: state_n = IDLE;
    endcase
    if (retire) state_n = run ? FETCH : IDLE;
  end
  // the wait counter only runs while parked in a waiting state and clears on any state change
  assign to_n = (waiting && state_n == state_q) ? to_q + TO_W'(1) : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      to_q    <= '0;
      retired <= '0;
    end else begin
      state_q <= state_n;
      op_q    <= fetch_ack ? mem.Op : op_q;
      to_q    <= to_n;
      retired <= retired + CNT_W'(retire);
    end
  end
endmodule
